tsense_seq: RTL and testbench

Measurement sequencer for the temperature-sensor comparator counter. It powers up the sensor front end and waits a settle interval. It then counts comparator-high cycles over a fixed gate window and publishes a registered result with a one-cycle valid strobe. It sits between the analog sensor (enable out, `voutc` in) and the digital readout logic, and supports single-shot and continuous measurement.

---
 rtl/tsense_seq.sv | 147 ++++++++++++++
 tb/tb_tsense_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tsense_seq.sv
// Temperature-sensor measurement sequencer: settle, gated comparator-high count, registered result.
// Optional build macro TSENSE_AVG_EN averages four consecutive windows into each published result.
module tsense_seq #(
   parameter int unsigned WINDOW = 5907,
   parameter int unsigned SETTLE = 64,
   parameter int unsigned CW     = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          continuous,
   input  logic          voutc,
   output logic          sensor_en,
   output logic          busy,
   output logic [CW-1:0] result,
   output logic          valid,
   output logic          ovf
);

   localparam logic [14:0]   WinLoad = 15'(WINDOW - 1);
   localparam logic [9:0]    SetLoad = 10'(SETTLE - 1);
   localparam logic [CW-1:0] ResMax  = '1;

   typedef enum logic [1:0] {StIdle, StSettle, StCount, StDone} state_e;

   state_e        state_q;
   logic          meta_q;
   logic          vs_q;
   logic [9:0]    set_cnt_q;
   logic [14:0]   win_cnt_q;
   logic [CW:0]   acc_q;
   logic [CW:0]   acc_inc;

   // Accumulator sticks once its top bit is set, i.e. at a true count of 2^CW.
   always_comb begin
      acc_inc = acc_q + {{CW{1'b0}}, (vs_q & ~acc_q[CW])};
   end

`ifdef TSENSE_AVG_EN
   logic [1:0]    win_idx_q;
   logic [CW+2:0] sum_q;
   logic [CW+2:0] sum_win;
   logic [CW:0]   avg;
   logic          ovf_any_q;

   always_comb begin
      sum_win = sum_q + {2'b00, acc_inc};
      avg     = sum_q[CW+2:2];
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         meta_q    <= 1'b0;
         vs_q      <= 1'b0;
         set_cnt_q <= '0;
         win_cnt_q <= '0;
         acc_q     <= '0;
         sensor_en <= 1'b0;
         busy      <= 1'b0;
         result    <= '0;
         valid     <= 1'b0;
         ovf       <= 1'b0;
`ifdef TSENSE_AVG_EN
         win_idx_q <= '0;
         sum_q     <= '0;
         ovf_any_q <= 1'b0;
`endif
      end else begin
         meta_q <= voutc;
         vs_q   <= meta_q;
         valid  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q   <= StSettle;
                  set_cnt_q <= SetLoad;
                  sensor_en <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            StSettle: begin
               if (set_cnt_q == '0) begin
                  state_q   <= StCount;
                  win_cnt_q <= WinLoad;
                  acc_q     <= '0;
`ifdef TSENSE_AVG_EN
                  win_idx_q <= '0;
                  sum_q     <= '0;
                  ovf_any_q <= 1'b0;
`endif
               end else begin
                  set_cnt_q <= set_cnt_q - 10'd1;
               end
            end
            StCount: begin
               acc_q <= acc_inc;
               if (win_cnt_q == '0) begin
`ifdef TSENSE_AVG_EN
                  sum_q     <= sum_win;
                  ovf_any_q <= ovf_any_q | acc_inc[CW];
                  if (win_idx_q != 2'd3) begin
                     // Intermediate window: restart the gate without a publish cycle.
                     win_idx_q <= win_idx_q + 2'd1;
                     win_cnt_q <= WinLoad;
                     acc_q     <= '0;
                  end else begin
                     state_q <= StDone;
                  end
`else
                  state_q <= StDone;
`endif
               end else begin
                  win_cnt_q <= win_cnt_q - 15'd1;
               end
            end
            StDone: begin
               valid <= 1'b1;
`ifdef TSENSE_AVG_EN
               result <= avg[CW] ? ResMax : avg[CW-1:0];
               ovf    <= ovf_any_q;
`else
               result <= acc_q[CW] ? ResMax : acc_q[CW-1:0];
               ovf    <= acc_q[CW];
`endif
               if (continuous) begin
                  state_q   <= StCount;
                  win_cnt_q <= WinLoad;
                  acc_q     <= '0;
`ifdef TSENSE_AVG_EN
                  win_idx_q <= '0;
                  sum_q     <= '0;
                  ovf_any_q <= 1'b0;
`endif
               end else begin
                  state_q   <= StIdle;
                  sensor_en <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_tsense_seq.sv
// Scoreboard bench for tsense_seq: a short-window instance and a default-parameter instance.
module tb_tsense_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_a = 1'b0;
   logic       start_b = 1'b0;
   logic       continuous = 1'b0;
   logic       voutc = 1'b0;
   int         vmode = 0;

   logic       sensor_en_a, busy_a, valid_a, ovf_a;
   logic [7:0] result_a;
   logic       sensor_en_b, busy_b, valid_b, ovf_b;
   logic [7:0] result_b;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      int res;
      int ovf;
      int cyc;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   tsense_seq #(.WINDOW(20), .SETTLE(4), .CW(8)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .continuous(continuous), .voutc(voutc),
      .sensor_en(sensor_en_a), .busy(busy_a), .result(result_a), .valid(valid_a), .ovf(ovf_a)
   );

   tsense_seq dut_b (
      .clk(clk), .rst(rst), .start(start_b), .continuous(1'b0), .voutc(voutc),
      .sensor_en(sensor_en_b), .busy(busy_b), .result(result_b), .valid(valid_b), .ovf(ovf_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Comparator stimulus: 0 = low, 1 = high, 2 = toggle every cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (vmode == 2) voutc = ~voutc;
         else voutc = (vmode == 1);
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   always @(posedge clk) begin : mon_a
      exp_t e;
      #1;
      if (valid_a) begin
         if (q_a.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL a_unexpected_valid: valid=1 at cycle %0d, expected no valid", cyc);
         end else begin
            e = q_a.pop_front();
            chk("a_result", int'(result_a), e.res);
            chk("a_ovf", int'(ovf_a), e.ovf);
            chk("a_valid_cycle", cyc, e.cyc);
         end
      end
   end

   always @(posedge clk) begin : mon_b
      exp_t e;
      #1;
      if (valid_b) begin
         if (q_b.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL b_unexpected_valid: valid=1 at cycle %0d, expected no valid", cyc);
         end else begin
            e = q_b.pop_front();
            chk("b_result", int'(result_b), e.res);
            chk("b_ovf", int'(ovf_b), e.ovf);
            chk("b_valid_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic push_a(input int res, input int o, input int c);
      exp_t e;
      e.res = res; e.ovf = o; e.cyc = c;
      q_a.push_back(e);
   endtask

   // Returns the cycle index of the edge that sampled start.
   task automatic fire_a(output int e);
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      #1;
      e = cyc;
      @(negedge clk);
      start_a = 1'b0;
   endtask

   task automatic drain_a(input int budget);
      int n = 0;
      while (q_a.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #2;
      if (q_a.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL a_timeout: %0d results still pending, expected 0", q_a.size());
         q_a.delete();
      end
   endtask

   initial begin
      int e;
      int lows;
      exp_t x;

      // Reset with start held high.
      start_a = 1'b1;
      start_b = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_sensor_en", int'(sensor_en_a), 0);
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_result", int'(result_a), 0);
      chk("rst_valid", int'(valid_a), 0);
      chk("rst_ovf", int'(ovf_a), 0);
      chk("rst_b_busy", int'(busy_b), 0);
      rst = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;

      // voutc held high: full-window count.
      vmode = 1;
      repeat (4) @(negedge clk);
      fire_a(e);
      push_a(20, 0, e + 25);
      chk("a_busy_at_start", int'(busy_a), 1);
      chk("a_sensor_en_at_start", int'(sensor_en_a), 1);
      drain_a(60);
      @(negedge clk);
      chk("a_busy_after", int'(busy_a), 0);
      chk("a_sensor_en_after", int'(sensor_en_a), 0);
      repeat (5) @(negedge clk);
      chk("a_result_hold", int'(result_a), 20);

      // Toggling comparator gives half the window.
      vmode = 2;
      fire_a(e);
      push_a(10, 0, e + 25);
      drain_a(60);

      // Comparator low.
      vmode = 0;
      repeat (3) @(negedge clk);
      fire_a(e);
      push_a(0, 0, e + 25);
      drain_a(60);

      // Default parameters saturate.
      vmode = 1;
      repeat (3) @(negedge clk);
      start_b = 1'b1;
      @(posedge clk);
      #1;
      e = cyc;
      x.res = 255; x.ovf = 1; x.cyc = e + 64 + 5907 + 1;
      q_b.push_back(x);
      @(negedge clk);
      start_b = 1'b0;
      for (int i = 0; i < 7000 && q_b.size() != 0; i++) @(posedge clk);
      #2;
      chk("b_pending", q_b.size(), 0);
      q_b.delete();

      // Continuous mode, dropped mid-way through the fourth window.
      continuous = 1'b1;
      fire_a(e);
      for (int k = 0; k < 4; k++) push_a(20, 0, e + 25 + 21 * k);
      lows = 0;
      while (cyc < e + 75) begin
         if (!sensor_en_a) lows++;
         @(negedge clk);
      end
      continuous = 1'b0;
      while (cyc < e + 88) begin
         if (!sensor_en_a) lows++;
         @(negedge clk);
      end
      chk("a_cont_sensor_en_lows", lows, 0);
      drain_a(40);
      repeat (30) @(negedge clk);
      chk("a_cont_busy_after", int'(busy_a), 0);

      // Reset during COUNT aborts without a strobe.
      fire_a(e);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("a_abort_busy", int'(busy_a), 0);
      chk("a_abort_sensor_en", int'(sensor_en_a), 0);
      chk("a_abort_result", int'(result_a), 0);
      repeat (40) @(negedge clk);

      // Fresh measurement after the abort.
      vmode = 2;
      fire_a(e);
      push_a(10, 0, e + 25);
      drain_a(60);
      repeat (10) @(negedge clk);
      chk("a_final_pending", q_a.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
